// File: rtl/req_ingress_arb_pkg.sv
// Shared types and helpers for the request ingress arbiter and the retry engine.
// Holds the QoS width, request-type encoding and the round-robin picker.
package req_ingress_arb_pkg;

  localparam int unsigned QOS_W      = 4;
  localparam int unsigned RR_MAX_SRC = 32;
  localparam int unsigned RR_IDX_W   = $clog2(RR_MAX_SRC);

  typedef enum logic {
    REQ_NO_RTY = 1'b0,
    REQ_RTY    = 1'b1
  } req_type_e;

  // First set bit of req[num-1:0] searching upward from ptr+1 with wrap.
  // Returns ptr when nothing is requested.
  function automatic int unsigned rr_first_from(
    input logic [RR_MAX_SRC-1:0] req,
    input int unsigned           ptr,
    input int unsigned           num
  );
    int unsigned idx;
    rr_first_from = ptr;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int unsigned i = RR_MAX_SRC; i >= 1; i--) begin
      if (i <= num) begin
        idx = (ptr + i) % num;
        if (req[idx[RR_IDX_W-1:0]]) rr_first_from = idx;
      end
    end
  endfunction

endpackage

// File: rtl/req_ingress_arb_src_fifo.sv
// Per-source synchronous FIFO with full/empty/count status.
// Pointers wrap naturally because DEPTH is a power of two.
module req_src_fifo
  import req_ingress_arb_pkg::*;
#(
  parameter  int unsigned DATA_W = 13,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/req_ingress_arb.sv
// QoS-aware ingress arbiter: per-source FIFOs, QoS/round-robin selection with
// an age-based starvation override, and one registered valid/ready output.
module req_ingress_arb
  import req_ingress_arb_pkg::*;
#(
  parameter  int unsigned SRC_NODE_W = 2,
  parameter  int unsigned PAYLD_BW   = 8,
  parameter  int unsigned FIFO_DEPTH = 4,
  parameter  int unsigned AGE_TH     = 8,
  localparam int unsigned SRC_NUM    = 2 ** SRC_NODE_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SRC_NUM-1:0]          vld_src_in,
  output logic [SRC_NUM-1:0]          rdy_src_in,
  input  logic [SRC_NUM-1:0]          src_req_type,
  input  logic [QOS_W*SRC_NUM-1:0]    src_qos,
  input  logic [PAYLD_BW*SRC_NUM-1:0] src_payload,
  output logic                        vld_req_out,
  input  logic                        rdy_req_out,
  output logic                        req_type,
  output logic [QOS_W-1:0]            qos_type,
  output logic [SRC_NODE_W-1:0]       src_id,
  output logic [PAYLD_BW-1:0]         payload_out
);

  localparam int unsigned ENT_W = 1 + QOS_W + PAYLD_BW;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AGE_W = $clog2(AGE_TH + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_TH);

  logic [ENT_W-1:0]    fifo_wdata [SRC_NUM];
  logic [ENT_W-1:0]    fifo_rdata [SRC_NUM];
  logic [CNT_W-1:0]    fifo_cnt   [SRC_NUM];
  logic [SRC_NUM-1:0]  fifo_full;
  logic [SRC_NUM-1:0]  fifo_empty;
  logic [SRC_NUM-1:0]  head_vld;
  logic [SRC_NUM-1:0]  pop;
  logic [SRC_NUM-1:0]  forced;
  logic [SRC_NUM-1:0]  cand;
  logic                head_type  [SRC_NUM];
  logic [QOS_W-1:0]    head_qos   [SRC_NUM];
  logic [PAYLD_BW-1:0] head_pay   [SRC_NUM];
  logic [AGE_W-1:0]    age        [SRC_NUM];
  logic [QOS_W-1:0]    qmax       [SRC_NUM+1];
  logic [SRC_NODE_W-1:0] rr_ptr;
  logic [SRC_NODE_W-1:0] win;
  logic                load;

  assign qmax[0] = '0;

  for (genvar g = 0; g < SRC_NUM; g++) begin : g_src
    assign fifo_wdata[g] = {src_req_type[g],
                            src_qos[QOS_W*g +: QOS_W],
                            src_payload[PAYLD_BW*g +: PAYLD_BW]};

    req_src_fifo #(
      .DATA_W (ENT_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (vld_src_in[g]),
      .wr_data (fifo_wdata[g]),
      .rd_en   (pop[g]),
      .rd_data (fifo_rdata[g]),
      .full    (fifo_full[g]),
      .empty   (fifo_empty[g]),
      .count   (fifo_cnt[g])
    );

    assign rdy_src_in[g] = ~fifo_full[g];
    assign head_vld[g]   = (fifo_cnt[g] != '0);
    assign head_type[g]  = fifo_rdata[g][ENT_W-1];
    assign head_qos[g]   = fifo_rdata[g][PAYLD_BW +: QOS_W];
    assign head_pay[g]   = fifo_rdata[g][PAYLD_BW-1:0];

    // Running maximum over valid heads; empty heads contribute nothing.
    assign qmax[g+1] = (head_vld[g] && head_qos[g] > qmax[g]) ? head_qos[g] : qmax[g];

    assign forced[g] = head_vld[g] & (age[g] == AGE_MAX);
    assign cand[g]   = (|forced) ? forced[g]
                                 : (head_vld[g] & (head_qos[g] == qmax[SRC_NUM]));
    assign pop[g]    = load & (win == SRC_NODE_W'(g));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        age[g] <= '0;
      end else if (fifo_empty[g] || pop[g]) begin
        age[g] <= '0;
      end else if (load && age[g] != AGE_MAX) begin
        age[g] <= age[g] + AGE_W'(1);
      end
    end
  end

  assign load = (~vld_req_out | rdy_req_out) & (|head_vld);
  assign win  = SRC_NODE_W'(rr_first_from(RR_MAX_SRC'(cand), 32'(rr_ptr), SRC_NUM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_req_out <= 1'b0;
      req_type    <= REQ_NO_RTY;
      qos_type    <= '0;
      src_id      <= '0;
      payload_out <= '0;
      rr_ptr      <= '1;
    end else if (load) begin
      vld_req_out <= 1'b1;
      req_type    <= head_type[win];
      qos_type    <= head_qos[win];
      src_id      <= win;
      payload_out <= head_pay[win];
      rr_ptr      <= win;
    end else if (rdy_req_out) begin
      vld_req_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_req_ingress_arb.sv
// Randomised bench for req_ingress_arb against a queue-based reference model,
// plus directed latency, QoS order, starvation and mid-stream reset scenarios.
module tb_req_ingress_arb;

  localparam int unsigned NW  = 2;
  localparam int unsigned NS  = 4;
  localparam int unsigned PW  = 8;
  localparam int unsigned QW  = 4;
  localparam int unsigned FD  = 4;
  localparam int unsigned ATH = 8;

  typedef struct packed {
    logic          t;
    logic [QW-1:0] q;
    logic [PW-1:0] p;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NS-1:0]    vld_src_in;
  logic [NS-1:0]    rdy_src_in;
  logic [NS-1:0]    src_req_type;
  logic [QW*NS-1:0] src_qos;
  logic [PW*NS-1:0] src_payload;
  logic             vld_req_out;
  logic             rdy_req_out;
  logic             req_type;
  logic [QW-1:0]    qos_type;
  logic [NW-1:0]    src_id;
  logic [PW-1:0]    payload_out;

  req_ingress_arb #(
    .SRC_NODE_W (NW),
    .PAYLD_BW   (PW),
    .FIFO_DEPTH (FD),
    .AGE_TH     (ATH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vld_src_in   (vld_src_in),
    .rdy_src_in   (rdy_src_in),
    .src_req_type (src_req_type),
    .src_qos      (src_qos),
    .src_payload  (src_payload),
    .vld_req_out  (vld_req_out),
    .rdy_req_out  (rdy_req_out),
    .req_type     (req_type),
    .qos_type     (qos_type),
    .src_id       (src_id),
    .payload_out  (payload_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  ent_t        mq [NS][$];
  int unsigned m_age [NS];
  int unsigned m_rr;
  int unsigned m_vld, m_type, m_qos, m_id, m_pay;

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int unsigned i = 0; i < NS; i++) begin
      mq[i].delete();
      m_age[i] = 0;
    end
    m_rr = NS - 1;
    m_vld = 0; m_type = 0; m_qos = 0; m_id = 0; m_pay = 0;
  endtask

  // Applies one clock edge worth of the arbitration rules to the model.
  task automatic model_step();
    bit          was_empty [NS];
    bit          cand [NS];
    bit          acc [NS];
    bit          any, load, anyf;
    int unsigned mxq, w, idx;
    ent_t        e;
    any = 0;
    for (int unsigned i = 0; i < NS; i++) begin
      was_empty[i] = (mq[i].size() == 0);
      if (!was_empty[i]) any = 1;
    end
    load = ((m_vld == 0) || rdy_req_out) && any;
    w = 0;
    if (load) begin
      anyf = 0;
      mxq  = 0;
      for (int unsigned i = 0; i < NS; i++) begin
        if (!was_empty[i] && m_age[i] == ATH) anyf = 1;
        if (!was_empty[i] && int'(mq[i][0].q) > int'(mxq)) mxq = mq[i][0].q;
      end
      for (int unsigned i = 0; i < NS; i++)
        cand[i] = anyf ? (!was_empty[i] && m_age[i] == ATH)
                       : (!was_empty[i] && mq[i][0].q == mxq);
      for (int unsigned k = 1; k <= NS; k++) begin
        idx = (m_rr + k) % NS;
        if (cand[idx]) begin
          w = idx;
          break;
        end
      end
    end
    for (int unsigned i = 0; i < NS; i++) begin
      acc[i] = vld_src_in[i] && (mq[i].size() < FD);
      if (was_empty[i] || (load && i == w)) m_age[i] = 0;
      else if (load) m_age[i] = (m_age[i] < ATH) ? m_age[i] + 1 : ATH;
    end
    if (load) begin
      e = mq[w].pop_front();
      m_vld = 1; m_type = e.t; m_qos = e.q; m_pay = e.p; m_id = w; m_rr = w;
    end else if (rdy_req_out) begin
      m_vld = 0;
    end
    for (int unsigned i = 0; i < NS; i++)
      if (acc[i]) mq[i].push_back({src_req_type[i], src_qos[QW*i +: QW], src_payload[PW*i +: PW]});
  endtask

  task automatic check_outputs();
    int unsigned exp_rdy;
    exp_rdy = 0;
    for (int unsigned i = 0; i < NS; i++)
      if (mq[i].size() < FD) exp_rdy |= (1 << i);
    chk("vld_req_out", 32'(vld_req_out), m_vld);
    chk("src_id", 32'(src_id), m_id);
    chk("qos_type", 32'(qos_type), m_qos);
    chk("payload_out", 32'(payload_out), m_pay);
    chk("req_type", 32'(req_type), m_type);
    chk("rdy_src_in", 32'(rdy_src_in), exp_rdy);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_src(input int unsigned i, input logic t, input logic [QW-1:0] q, input logic [PW-1:0] p);
    src_req_type[i]      = t;
    src_qos[QW*i +: QW]  = q;
    src_payload[PW*i +: PW] = p;
  endtask

  task automatic drive_rand(input int unsigned push_pct, input int unsigned qos_fix, input int unsigned rdy_pct);
    for (int unsigned i = 0; i < NS; i++) begin
      vld_src_in[i] = ($urandom_range(99) < push_pct);
      set_src(i, 1'($urandom), (qos_fix > 15) ? 4'($urandom) : 4'(qos_fix), 8'($urandom));
    end
    rdy_req_out = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vld_src_in  = '0;
    rdy_req_out = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
  endtask

  int unsigned ph_push [6] = '{30, 90, 100, 60, 100, 70};
  int unsigned ph_rdy  [6] = '{100, 40, 0, 80, 100, 50};
  int unsigned ph_len  [6] = '{60, 80, 12, 100, 40, 120};
  int unsigned ph_qos  [6] = '{16, 16, 16, 16, 7, 16};
  int unsigned exp_order [3] = '{1, 3, 0};

  initial begin
    int unsigned n_src1;
    bit          seen0;
    rst_n        = 1'b0;
    vld_src_in   = '0;
    src_req_type = '0;
    src_qos      = '0;
    src_payload  = '0;
    rdy_req_out  = 1'b0;
    model_reset();
    #1;
    chk("reset_vld", 32'(vld_req_out), 0);
    chk("reset_rdy_src", 32'(rdy_src_in), 32'hF);
    chk("reset_src_id", 32'(src_id), 0);
    apply_reset();

    // Single source: push on one edge, visible after the next.
    set_src(2, 1'b1, 4'd5, 8'h3C);
    vld_src_in  = 4'b0100;
    rdy_req_out = 1'b1;
    cycle();
    vld_src_in = '0;
    cycle();
    chk("single_vld", 32'(vld_req_out), 1);
    chk("single_src_id", 32'(src_id), 2);
    chk("single_qos", 32'(qos_type), 5);
    chk("single_payload", 32'(payload_out), 32'h3C);
    chk("single_type", 32'(req_type), 1);
    repeat (2) cycle();

    // QoS order with round-robin tie-break.
    apply_reset();
    set_src(0, 1'b0, 4'd2, 8'hA0);
    set_src(1, 1'b1, 4'd9, 8'hA1);
    set_src(3, 1'b0, 4'd9, 8'hA3);
    vld_src_in  = 4'b1011;
    rdy_req_out = 1'b1;
    cycle();
    vld_src_in = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      cycle();
      chk("qos_order", 32'(src_id), exp_order[k]);
    end
    cycle();

    // Starvation override: low-QoS head wins on the load after AGE_TH losses.
    apply_reset();
    set_src(0, 1'b0, 4'd0, 8'h55);
    set_src(1, 1'b1, 4'd15, 8'h11);
    vld_src_in  = 4'b0011;
    rdy_req_out = 1'b1;
    cycle();
    vld_src_in = 4'b0010;
    n_src1 = 0;
    seen0  = 0;
    for (int unsigned k = 0; k < 20 && !seen0; k++) begin
      cycle();
      if (vld_req_out && src_id == 0) seen0 = 1;
      else if (vld_req_out && src_id == 1) n_src1++;
    end
    chk("starve_seen", 32'(seen0), 1);
    chk("starve_losses", n_src1, ATH);
    vld_src_in = '0;
    repeat (4) cycle();

    // Randomised phases: light load, back-pressure, full FIFOs, equal-QoS streaming.
    apply_reset();
    for (int unsigned p = 0; p < 6; p++) begin
      for (int unsigned c = 0; c < ph_len[p]; c++) begin
        drive_rand(ph_push[p], ph_qos[p], ph_rdy[p]);
        cycle();
      end
    end

    // Reset while traffic is pending.
    vld_src_in  = 4'b1011;
    rdy_req_out = 1'b0;
    repeat (3) cycle();
    vld_src_in = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", 32'(vld_req_out), 0);
    chk("midrst_rdy_src", 32'(rdy_src_in), 32'hF);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_src(3, 1'b1, 4'd4, 8'hC3);
    vld_src_in  = 4'b1000;
    rdy_req_out = 1'b1;
    cycle();
    vld_src_in = '0;
    cycle();
    chk("postrst_vld", 32'(vld_req_out), 1);
    chk("postrst_src_id", 32'(src_id), 3);
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
